// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared widths and kernel weights for the 3x3 gaussian filter
package gauss_pkg;

   localparam int DATA_W     = 8;
   localparam int SUM_W      = DATA_W + 4;
   localparam int NORM_SHIFT = 4;

   // kernel weights 1/2/4 held as left-shift amounts
   localparam int W_CORNER_SH = 0;
   localparam int W_EDGE_SH   = 1;
   localparam int W_CENTRE_SH = 2;

endpackage

// File: rtl/gauss_row_sum.sv
// rtl/gauss_row_sum.sv - one kernel row: a + 2b + c
module gauss_row_sum #(
   parameter int DATA_W = gauss_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W+1:0] sum
);

   import gauss_pkg::*;

   assign sum = ({2'b00, a} << W_CORNER_SH)
              + ({2'b00, b} << W_EDGE_SH)
              + ({2'b00, c} << W_CORNER_SH);

endmodule

// File: rtl/gauss_filter.sv
// rtl/gauss_filter.sv - 3x3 gaussian smoothing, combinational sum, registered result
module gauss_filter #(
   parameter int DATA_W = gauss_pkg::DATA_W
) (
   input  logic              clk_i_g,
   input  logic              rst_i_g,
   input  logic              en_i_g,
   input  logic [DATA_W-1:0] data_i_0,
   input  logic [DATA_W-1:0] data_i_1,
   input  logic [DATA_W-1:0] data_i_2,
   input  logic [DATA_W-1:0] data_i_3,
   input  logic [DATA_W-1:0] data_i_4,
   input  logic [DATA_W-1:0] data_i_5,
   input  logic [DATA_W-1:0] data_i_6,
   input  logic [DATA_W-1:0] data_i_7,
   input  logic [DATA_W-1:0] data_i_8,
   output logic [DATA_W-1:0] data_o,
   output logic              sonuc_done
);

   import gauss_pkg::*;

   localparam int RSUM_W = DATA_W + 2;
   localparam int TSUM_W = DATA_W + 4;

   logic [RSUM_W-1:0]     top_sum;
   logic [RSUM_W-1:0]     mid_sum;
   logic [RSUM_W-1:0]     bot_sum;
   logic [TSUM_W-1:0]     total;
   logic [DATA_W-1:0]     result;
   logic [NORM_SHIFT-1:0] frac_unused;

   gauss_row_sum #(.DATA_W(DATA_W)) u_top (
      .a(data_i_0), .b(data_i_1), .c(data_i_2), .sum(top_sum)
   );
   gauss_row_sum #(.DATA_W(DATA_W)) u_mid (
      .a(data_i_3), .b(data_i_4), .c(data_i_5), .sum(mid_sum)
   );
   gauss_row_sum #(.DATA_W(DATA_W)) u_bot (
      .a(data_i_6), .b(data_i_7), .c(data_i_8), .sum(bot_sum)
   );

   // middle row carries the edge weight again, giving 2/4/2 overall
   assign total = {2'b00, top_sum}
                + ({2'b00, mid_sum} << W_EDGE_SH)
                + {2'b00, bot_sum};

   // divide by 16 with truncation; max 4080 so the upper bits always fit DATA_W
   assign {result, frac_unused} = total;

   always_ff @(posedge clk_i_g) begin
      if (!rst_i_g) begin
         data_o     <= '0;
         sonuc_done <= 1'b0;
      end else if (en_i_g) begin
         data_o     <= result;
         sonuc_done <= 1'b1;
      end else begin
         sonuc_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gauss_filter.sv
// tb/tb_gauss_filter.sv - directed and random checks of gauss_filter against a weighted-sum model
module tb_gauss_filter;

   logic       clk_i_g = 1'b0;
   logic       rst_i_g;
   logic       en_i_g;
   logic [7:0] data_i_0, data_i_1, data_i_2, data_i_3, data_i_4;
   logic [7:0] data_i_5, data_i_6, data_i_7, data_i_8;
   logic [7:0] data_o;
   logic       sonuc_done;

   logic [7:0] win [9];
   int         weights [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   logic [7:0] exp_data;
   logic       exp_done;
   int         n_vec = 0;
   int         n_bad = 0;

   always #5 clk_i_g = ~clk_i_g;

   gauss_filter dut (
      .clk_i_g   (clk_i_g),
      .rst_i_g   (rst_i_g),
      .en_i_g    (en_i_g),
      .data_i_0  (data_i_0),
      .data_i_1  (data_i_1),
      .data_i_2  (data_i_2),
      .data_i_3  (data_i_3),
      .data_i_4  (data_i_4),
      .data_i_5  (data_i_5),
      .data_i_6  (data_i_6),
      .data_i_7  (data_i_7),
      .data_i_8  (data_i_8),
      .data_o    (data_o),
      .sonuc_done(sonuc_done)
   );

   function automatic logic [7:0] ref_pixel();
      int s = 0;
      for (int i = 0; i < 9; i++) s += weights[i] * int'(win[i]);
      return 8'(s / 16);
   endfunction

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 9; i++) win[i] = v;
   endtask

   task automatic check(input string tag, input logic [7:0] d, input logic v);
      n_vec++;
      assert (data_o === d) else begin
         n_bad++;
         $error("FAIL %s data_o observed %0d expected %0d", tag, data_o, d);
      end
      n_vec++;
      assert (sonuc_done === v) else begin
         n_bad++;
         $error("FAIL %s sonuc_done observed %0b expected %0b", tag, sonuc_done, v);
      end
   endtask

   // one clock: drive on negedge, advance the model at the edge, compare just after
   task automatic apply(input string tag, input logic en, input logic rst);
      @(negedge clk_i_g);
      rst_i_g  = rst;
      en_i_g   = en;
      data_i_0 = win[0]; data_i_1 = win[1]; data_i_2 = win[2];
      data_i_3 = win[3]; data_i_4 = win[4]; data_i_5 = win[5];
      data_i_6 = win[6]; data_i_7 = win[7]; data_i_8 = win[8];
      @(posedge clk_i_g);
      if (!rst) begin
         exp_data = 8'd0;
         exp_done = 1'b0;
      end else if (en) begin
         exp_data = ref_pixel();
         exp_done = 1'b1;
      end else begin
         exp_done = 1'b0;
      end
      #1;
      check(tag, exp_data, exp_done);
   endtask

   task automatic expect_const(input string tag, input logic [7:0] d, input logic v);
      check(tag, d, v);
   endtask

   initial begin
      exp_data = 8'd0;
      exp_done = 1'b0;
      fill(8'd77);
      apply("reset_en", 1'b1, 1'b0);
      expect_const("reset_const", 8'd0, 1'b0);

      fill(8'd100);
      apply("uniform100", 1'b1, 1'b1);
      expect_const("uniform100_const", 8'd100, 1'b1);

      fill(8'd255);
      apply("uniform255", 1'b1, 1'b1);
      expect_const("uniform255_const", 8'd255, 1'b1);

      fill(8'd0); win[4] = 8'd255;
      apply("centre", 1'b1, 1'b1);
      expect_const("centre_const", 8'd63, 1'b1);

      fill(8'd0); win[0] = 8'd16; win[2] = 8'd16; win[6] = 8'd16; win[8] = 8'd16;
      apply("corners", 1'b1, 1'b1);
      expect_const("corners_const", 8'd4, 1'b1);

      fill(8'd0); win[1] = 8'd3; win[3] = 8'd3; win[5] = 8'd3; win[7] = 8'd3;
      apply("edges_trunc", 1'b1, 1'b1);
      expect_const("edges_trunc_const", 8'd1, 1'b1);

      fill(8'd100); apply("b2b_0", 1'b1, 1'b1);
      expect_const("b2b_0_const", 8'd100, 1'b1);
      fill(8'd255); apply("b2b_1", 1'b1, 1'b1);
      expect_const("b2b_1_const", 8'd255, 1'b1);
      fill(8'd0);   apply("b2b_2", 1'b1, 1'b1);
      expect_const("b2b_2_const", 8'd0, 1'b1);

      fill(8'd200); apply("drop_pre", 1'b1, 1'b1);
      fill(8'd9);   apply("drop_low", 1'b0, 1'b1);
      expect_const("drop_low_const", 8'd200, 1'b0);
      fill(8'd50);  apply("drop_post", 1'b1, 1'b1);
      expect_const("drop_post_const", 8'd50, 1'b1);

      fill(8'd123); apply("midrst", 1'b1, 1'b0);
      expect_const("midrst_const", 8'd0, 1'b0);
      fill(8'd80);  apply("after_rst", 1'b1, 1'b1);
      expect_const("after_rst_const", 8'd80, 1'b1);

      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(0, 255));
         apply("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
